// File: rtl/coin_credit_ctrl.sv
// coin_credit_ctrl: coin window sampler, classifier and digit-serial BCD credit adder
module coin_credit_ctrl #(
  parameter int WINDOW_CYCLES = 25_000_000,
  parameter int QUIET_CYCLES  = 50_000
) (
  input  logic        CLK_50,
  input  logic        rst,
  input  logic [4:0]  coin,
  input  logic        clr,
  output logic [31:0] credit,
  output logic        busy,
  output logic        coin_valid,
  output logic [2:0]  coin_code,
  output logic        coin_reject,
  output logic        overflow
);
  localparam int CW = $clog2(WINDOW_CYCLES + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SAMPLE, CLASSIFY, ADD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [4:0] sync_q, coin_s_q, seen_q, seen_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [31:0] work_q, work_d, credit_q, credit_d, addend;
  logic [2:0] digit_q, digit_d, code_q, code_d, code;
  logic carry_q, carry_d, ovf_q, ovf_d;
  logic [4:0] s;
  assign code = seen_q == 5'b00001 ? 3'd1 :
                seen_q == 5'b00011 ? 3'd2 :
                seen_q == 5'b00111 ? 3'd3 :
                seen_q == 5'b01111 ? 3'd4 :
                seen_q == 5'b11111 ? 3'd5 : 3'd0;
  assign addend = code == 3'd1 ? 32'h5  :
                  code == 3'd2 ? 32'h10 :
                  code == 3'd3 ? 32'h20 :
                  code == 3'd4 ? 32'h50 :
                  code == 3'd5 ? 32'h100 : 32'h0;
  assign credit    = credit_q;
  assign busy      = state_q != IDLE;
  assign coin_code = code_q;
  assign overflow  = ovf_q;
  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    cnt_d       = cnt_q;
    qcnt_d      = qcnt_q;
    work_d      = work_q;
    digit_d     = digit_q;
    carry_d     = carry_q;
    credit_d    = credit_q;
    code_d      = code_q;
    ovf_d       = ovf_q;
    coin_valid  = 1'b0;
    coin_reject = 1'b0;
    s = {1'b0, work_q[{digit_q, 2'b00} +: 4]} + {1'b0, addend[{digit_q, 2'b00} +: 4]} + {4'b0, carry_q};
    case (state_q)
      IDLE: if (|coin_s_q) begin
        state_d = SAMPLE;
        seen_d  = coin_s_q;
        cnt_d   = CW'(1);
      end
      SAMPLE: begin
        seen_d = seen_q | coin_s_q;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_d == CW'(WINDOW_CYCLES)) state_d = CLASSIFY;
      end
      CLASSIFY: begin
        work_d      = credit_q;
        digit_d     = 3'd0;
        carry_d     = 1'b0;
        qcnt_d      = '0;
        coin_reject = code == 3'd0;
        state_d     = code == 3'd0 ? RELEASE : ADD;
      end
      ADD: begin
        work_d[{digit_q, 2'b00} +: 4] = s > 5'd9 ? s[3:0] - 4'd10 : s[3:0];
        carry_d = s > 5'd9;
        digit_d = digit_q + 3'd1;
        if (digit_q == 3'd7) begin
          credit_d   = carry_d ? 32'h9999_9999 : work_d;
          ovf_d      = ovf_q | carry_d;
          code_d     = code;
          coin_valid = 1'b1;
          qcnt_d     = '0;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        qcnt_d = |coin_s_q ? '0 : qcnt_q + QW'(1);
        if (qcnt_d == QW'(QUIET_CYCLES)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // clear discards any coin in flight, including a commit due this cycle
    if (clr) begin
      credit_d    = '0;
      ovf_d       = 1'b0;
      code_d      = code_q;
      coin_valid  = 1'b0;
      coin_reject = 1'b0;
      qcnt_d      = '0;
      state_d     = state_q == IDLE ? IDLE : RELEASE;
    end
  end
  always_ff @(posedge CLK_50) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      coin_s_q <= '0;
      seen_q   <= '0;
      cnt_q    <= '0;
      qcnt_q   <= '0;
      work_q   <= '0;
      digit_q  <= '0;
      carry_q  <= 1'b0;
      credit_q <= '0;
      code_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= coin;
      coin_s_q <= sync_q;
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
      qcnt_q   <= qcnt_d;
      work_q   <= work_d;
      digit_q  <= digit_d;
      carry_q  <= carry_d;
      credit_q <= credit_d;
      code_q   <= code_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_coin_credit_ctrl.sv
// tb_coin_credit_ctrl: directed and random coin traffic against a decimal credit model
module tb_coin_credit_ctrl;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [4:0] coin = '0;
  logic [31:0] credit;
  logic busy, coin_valid, coin_reject, overflow;
  logic [2:0] coin_code;
  always #5 clk = ~clk;
  coin_credit_ctrl #(.WINDOW_CYCLES(8), .QUIET_CYCLES(4)) dut (
    .CLK_50(clk), .rst(rst), .coin(coin), .clr(clr), .credit(credit), .busy(busy),
    .coin_valid(coin_valid), .coin_code(coin_code), .coin_reject(coin_reject), .overflow(overflow)
  );
  int passed = 0, total = 0;
  int vals[6] = '{0, 5, 10, 20, 50, 100};
  int m_credit, m_code, ph, seen, win, left, quiet;
  bit m_ovf;
  logic [4:0] sy1, sy2;
  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic bit legal(int p);
    return p != 0 && ((p + 1) & p) == 0;
  endfunction
  function automatic int ones(int p);
    return $countones(p[4:0]);
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic model_reset();
    m_credit = 0; m_code = 0; m_ovf = 0; ph = 0;
    seen = 0; win = 0; left = 0; quiet = 0; sy1 = '0; sy2 = '0;
  endtask
  task automatic advance(logic [4:0] c, logic cl);
    int cs = int'(sy2);
    sy2 = sy1;
    sy1 = c;
    if (cl) begin
      m_credit = 0; m_ovf = 0; quiet = 0;
      if (ph != 0) ph = 4;
    end else
      case (ph)
        0: if (cs != 0) begin ph = 1; seen = cs; win = 1; end
        1: begin seen |= cs; win++; if (win == 8) ph = 2; end
        2: if (legal(seen)) begin ph = 3; left = 8; end else begin ph = 4; quiet = 0; end
        3: begin
          left--;
          if (left == 0) begin
            m_credit += vals[ones(seen)];
            if (m_credit > 99999999) begin m_credit = 99999999; m_ovf = 1; end
            m_code = ones(seen);
            ph = 4;
            quiet = 0;
          end
        end
        default: begin
          quiet = cs != 0 ? 0 : quiet + 1;
          if (quiet == 4) ph = 0;
        end
      endcase
  endtask
  task automatic step(logic [4:0] c, logic cl);
    @(negedge clk);
    coin = c;
    clr = cl;
    #1;
    chk("credit", credit, to_bcd(m_credit));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("coin_code", 32'(coin_code), 32'(m_code));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("coin_valid", 32'(coin_valid), 32'(ph == 3 && left == 1 && !cl));
    chk("coin_reject", 32'(coin_reject), 32'(ph == 2 && !legal(seen) && !cl));
    advance(c, cl);
  endtask
  task automatic hold(logic [4:0] c, int n);
    for (int i = 0; i < n; i++) step(c, 1'b0);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && (ph != 0 || sy1 != 0 || sy2 != 0); i++) step(5'b0, 1'b0);
    step(5'b0, 1'b0);
    chk("idle_timeout", 32'(busy), 32'h0);
  endtask
  task automatic insert(logic [4:0] c, int n);
    hold(c, n);
    wait_idle();
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_credit", credit, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(coin_valid), 32'h0);
    chk("rst_code", 32'(coin_code), 32'h0);
    chk("rst_reject", 32'(coin_reject), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    insert(5'b00111, 3);
    chk("s1_credit", credit, 32'h20);
    chk("s1_code", 32'(coin_code), 32'd3);
    step(5'b0, 1'b1);
    wait_idle();
    insert(5'b01111, 3);
    chk("s2_a", credit, 32'h50);
    insert(5'b01111, 3);
    chk("s2_b", credit, 32'h100);
    insert(5'b00001, 3);
    chk("s2_c", credit, 32'h105);
    insert(5'b11111, 3);
    chk("s2_d", credit, 32'h205);
    insert(5'b00101, 2);
    chk("s3_credit", credit, 32'h205);
    chk("s3_code", 32'(coin_code), 32'd5);
    @(negedge clk);
    force dut.credit_q = 32'h9999_9990;
    m_credit = 99999990;
    step(5'b0, 1'b0);
    @(posedge clk);
    #1;
    release dut.credit_q;
    insert(5'b00111, 2);
    chk("s4_sat", credit, 32'h9999_9999);
    chk("s4_ovf", 32'(overflow), 32'h1);
    step(5'b0, 1'b1);
    wait_idle();
    chk("s4_clr", credit, 32'h0);
    chk("s4_ovf_clr", 32'(overflow), 32'h0);
    hold(5'b11111, 2);
    for (int i = 0; i < 50 && !(ph == 3 && left == 5); i++) step(5'b0, 1'b0);
    step(5'b0, 1'b1);
    wait_idle();
    chk("s5_credit", credit, 32'h0);
    hold(5'b00001, 30);
    chk("s6_busy", 32'(busy), 32'h1);
    wait_idle();
    chk("s6_credit", credit, 32'h5);
    for (int n = 0; n < 40; n++) begin
      logic [4:0] pat;
      int len;
      pat = $urandom_range(0, 3) == 0 ? 5'($urandom_range(1, 31)) : 5'((1 << $urandom_range(1, 5)) - 1);
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) step(pat, 1'($urandom_range(0, 29) == 0));
      for (int i = 0; i < 20; i++) step(5'b0, 1'($urandom_range(0, 39) == 0));
      wait_idle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
